// File: rtl/countdown_timer_if.sv
// Operator-side bundle of the countdown timer: raw controls in, count/status/HEX out.
// Pure wiring; no latency and no flow control.
interface countdown_timer_if;
    logic [15:0] load_value;
    logic        load;
    logic        start_n;
    logic        pause_n;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;

    modport master (
        output load_value, load, start_n, pause_n,
        input  count, running, done, HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  load_value, load, start_n, pause_n,
        output count, running, done, HEX0, HEX1, HEX2, HEX3
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable 16-bit countdown timer with synchronized operator controls and HEX display.
// Latency: control edges act 3 edges after the pin changes; HEX is combinational from count.
// Backpressure: none; events are single-cycle and lower-priority ones in the same cycle are dropped.
module hex_to_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    // Active-low segments, bit order gfedcba.
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module countdown_timer #(
    parameter int DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic load_s1, load_s2, load_prev;
    logic start_s1, start_s2, start_prev;
    logic pause_s1, pause_s2, pause_prev;
    logic load_ev, start_ev, pause_ev;
    logic start_eff, pause_eff;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;

    // Synchronizers reset to the inactive level so a button held through reset fires once afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_s1    <= 1'b0;
            load_s2    <= 1'b0;
            load_prev  <= 1'b0;
            start_s1   <= 1'b1;
            start_s2   <= 1'b1;
            start_prev <= 1'b1;
            pause_s1   <= 1'b1;
            pause_s2   <= 1'b1;
            pause_prev <= 1'b1;
        end else begin
            load_s1    <= bus.load;
            load_s2    <= load_s1;
            load_prev  <= load_s2;
            start_s1   <= bus.start_n;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            pause_s1   <= bus.pause_n;
            pause_s2   <= pause_s1;
            pause_prev <= pause_s2;
        end
    end

    assign load_ev   = load_s2 & ~load_prev;
    assign start_ev  = ~start_s2 & start_prev;
    assign pause_ev  = ~pause_s2 & pause_prev;
    assign pause_eff = pause_ev & ~load_ev;
    assign start_eff = start_ev & ~pause_ev & ~load_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        if (load_ev) begin
            cnt_d   = bus.load_value;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_eff) begin
                        if (cnt_q != 16'd0) begin
                            state_d = RUN;
                            presc_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    if (pause_eff) begin
                        state_d = PAUSE;
                    end else if (cnt_q == 16'd0) begin
                        state_d = DONE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        cnt_d   = cnt_q - 16'd1;
                        if (cnt_q == 16'd1)
                            state_d = DONE;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start_eff)
                        state_d = RUN;
                end
                DONE: begin
                    cnt_d = 16'd0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.count   = cnt_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);

    hex_to_seg u_hex0 (.nib(cnt_q[3:0]),   .seg(bus.HEX0));
    hex_to_seg u_hex1 (.nib(cnt_q[7:4]),   .seg(bus.HEX1));
    hex_to_seg u_hex2 (.nib(cnt_q[11:8]),  .seg(bus.HEX2));
    hex_to_seg u_hex3 (.nib(cnt_q[15:12]), .seg(bus.HEX3));
endmodule
